alu_exec_unit: RTL

- Execute-stage ALU driven by the 4-bit ALU control code from the ALU control decoder (ALUCtrl_o feeds ctrl_i here). Sits directly downstream of that decoder.
- Logic, add/sub and compare ops complete in one cycle.
- Arithmetic right shifts (sra/srav) run iteratively, one bit per cycle, under a start/busy/done handshake.
- The CPU control stalls on busy_o and writes result_o back on done_o.

---
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the CPU control and the execute-stage ALU.
// The master issues operations; the slave (the ALU) reports busy/done and results.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               start_i;
    logic [3:0]         ctrl_i;
    logic [WIDTH-1:0]   src1_i;
    logic [WIDTH-1:0]   src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;
    logic               zero_o;
    logic               overflow_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i, shamt_i,
        input  busy_o, done_o, result_o, zero_o, overflow_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
        output busy_o, done_o, result_o, zero_o, overflow_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, iterative one-bit-per-cycle
// arithmetic right shifts, all reported through a start/busy/done handshake.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_exec_unit_if.slave     bus
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [3:0] CtrlAnd  = 4'b0000;
    localparam logic [3:0] CtrlOr   = 4'b0001;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlSub  = 4'b0110;
    localparam logic [3:0] CtrlSlt  = 4'b0111;
    localparam logic [3:0] CtrlSra  = 4'b1000;
    localparam logic [3:0] CtrlSrav = 4'b1001;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt_sel;
    logic [WIDTH-1:0]   shreg_step;

    assign sum        = bus.src1_i + bus.src2_i;
    assign diff       = bus.src1_i - bus.src2_i;
    assign is_shift   = (bus.ctrl_i == CtrlSra) || (bus.ctrl_i == CtrlSrav);
    assign shamt_sel  = (bus.ctrl_i == CtrlSrav) ? bus.src1_i[SHAMT_W-1:0] : bus.shamt_i;
    assign shreg_step = {shreg_q[Msb], shreg_q[Msb:1]};

    // Single-cycle results are computed straight from the inputs on the capture edge.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ctrl_i)
            CtrlAnd: alu_res = bus.src1_i & bus.src2_i;
            CtrlOr:  alu_res = bus.src1_i | bus.src2_i;
            CtrlAdd: begin
                alu_res = sum;
                alu_ovf = (bus.src1_i[Msb] == bus.src2_i[Msb]) && (sum[Msb] != bus.src1_i[Msb]);
            end
            CtrlSub: begin
                alu_res = diff;
                alu_ovf = (bus.src1_i[Msb] != bus.src2_i[Msb]) && (diff[Msb] != bus.src1_i[Msb]);
            end
            CtrlSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        if (!is_shift) begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else if (shamt_sel == '0) begin
                            result_q <= bus.src2_i;
                            zero_q   <= (bus.src2_i == '0);
                            ovf_q    <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            shreg_q <= bus.src2_i;
                            cnt_q   <= shamt_sel;
                            busy_q  <= 1'b1;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    shreg_q <= shreg_step;
                    cnt_q   <= cnt_q - 1'b1;
                    // Count of 1 means this edge performs the final shift step.
                    if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        result_q <= shreg_step;
                        zero_q   <= (shreg_step == '0);
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = ovf_q;

endmodule
